// File: rtl/multicycle_sequencer.sv
// rtl/multicycle_sequencer.sv - multicycle FETCH/DECODE/EXEC/MEM/WB sequencer with run/step/halt/breakpoint
// Enables are registered and decoded from the next phase and latched class.
module multicycle_sequencer (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       step,
  input  logic       halt_req,
  input  logic [6:0] OP,
  input  logic [7:0] PC,
  input  logic       bp_en,
  input  logic [7:0] bp_addr,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       ResultSrc,
  output logic [2:0] state,
  output logic       busy,
  output logic       bp_hit,
  output logic       err,
  output logic [7:0] retired
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_ERR    = 3'd7
  } state_t;

  typedef enum logic [1:0] {
    C_R     = 2'd0,
    C_I     = 2'd1,
    C_LOAD  = 2'd2,
    C_STORE = 2'd3
  } cls_t;

  state_t     state_q, state_d;
  cls_t       cls_q, cls_d;
  logic       step_q;
  logic       step_mode_q, step_mode_d;
  logic       halt_pend_q, halt_pend_d;
  logic       bp_hit_q, bp_hit_d;
  logic       err_q, err_d;
  logic [7:0] retired_q, retired_d;
  logic       pcw_q, pcw_d, irw_q, irw_d, rw_q, rw_d, mw_q, mw_d, rs_q, rs_d;
  logic       busy_q, busy_d;

  logic       step_edge, bp_stop, bp_next, complete;
  logic [7:0] pc_next;

  assign step_edge = step & ~step_q;
  assign pc_next   = PC + 8'd4;
  assign bp_stop   = run & bp_en & (PC == bp_addr);
  assign bp_next   = bp_en & (pc_next == bp_addr);

  always_comb begin
    state_d     = state_q;
    cls_d       = cls_q;
    step_mode_d = step_mode_q;
    halt_pend_d = halt_pend_q;
    bp_hit_d    = bp_hit_q;
    err_d       = err_q;
    retired_d   = retired_q;
    complete    = 1'b0;

    case (state_q)
      S_IDLE: begin
        halt_pend_d = 1'b0;
        // A step edge overrides the breakpoint hold so the stopped instruction can be stepped over.
        if (bp_stop && step_edge) begin
          state_d     = S_FETCH;
          step_mode_d = 1'b1;
          bp_hit_d    = 1'b0;
        end else if (bp_stop) begin
          bp_hit_d = 1'b1;
        end else if (run) begin
          state_d     = S_FETCH;
          step_mode_d = 1'b0;
          bp_hit_d    = 1'b0;
        end else if (step_edge) begin
          state_d     = S_FETCH;
          step_mode_d = 1'b1;
          bp_hit_d    = 1'b0;
        end
      end
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        case (OP)
          7'b0110011: begin cls_d = C_R;     state_d = S_EXEC; end
          7'b0010011: begin cls_d = C_I;     state_d = S_EXEC; end
          7'b0000011: begin cls_d = C_LOAD;  state_d = S_EXEC; end
          7'b0100011: begin cls_d = C_STORE; state_d = S_EXEC; end
          default: begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end
        endcase
      end
      S_EXEC: state_d = (cls_q == C_LOAD || cls_q == C_STORE) ? S_MEM : S_WB;
      S_MEM: begin
        if (cls_q == C_STORE) complete = 1'b1;
        else                  state_d  = S_WB;
      end
      S_WB:  complete = 1'b1;
      S_ERR: state_d = S_ERR;
      default: state_d = S_IDLE;
    endcase

    if (busy_q && halt_req) halt_pend_d = 1'b1;

    if (complete) begin
      retired_d = retired_q + 8'd1;
      if (bp_next) begin
        state_d     = S_IDLE;
        bp_hit_d    = 1'b1;
        halt_pend_d = 1'b0;
      end else if (step_mode_q || halt_pend_q || halt_req || !run) begin
        state_d     = S_IDLE;
        halt_pend_d = 1'b0;
      end else begin
        state_d = S_FETCH;
      end
    end

    irw_d  = (state_d == S_FETCH);
    rw_d   = (state_d == S_WB);
    mw_d   = (state_d == S_MEM) && (cls_d == C_STORE);
    rs_d   = (state_d == S_WB) && (cls_d == C_LOAD);
    pcw_d  = (state_d == S_WB) || ((state_d == S_MEM) && (cls_d == C_STORE));
    busy_d = (state_d == S_FETCH) || (state_d == S_DECODE) || (state_d == S_EXEC) ||
             (state_d == S_MEM) || (state_d == S_WB);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cls_q       <= C_R;
      step_q      <= 1'b0;
      step_mode_q <= 1'b0;
      halt_pend_q <= 1'b0;
      bp_hit_q    <= 1'b0;
      err_q       <= 1'b0;
      retired_q   <= 8'd0;
      pcw_q       <= 1'b0;
      irw_q       <= 1'b0;
      rw_q        <= 1'b0;
      mw_q        <= 1'b0;
      rs_q        <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cls_q       <= cls_d;
      step_q      <= step;
      step_mode_q <= step_mode_d;
      halt_pend_q <= halt_pend_d;
      bp_hit_q    <= bp_hit_d;
      err_q       <= err_d;
      retired_q   <= retired_d;
      pcw_q       <= pcw_d;
      irw_q       <= irw_d;
      rw_q        <= rw_d;
      mw_q        <= mw_d;
      rs_q        <= rs_d;
      busy_q      <= busy_d;
    end
  end

  assign state     = state_q;
  assign PCWrite   = pcw_q;
  assign IRWrite   = irw_q;
  assign RegWrite  = rw_q;
  assign MemWrite  = mw_q;
  assign ResultSrc = rs_q;
  assign busy      = busy_q;
  assign bp_hit    = bp_hit_q;
  assign err       = err_q;
  assign retired   = retired_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// tb/tb_multicycle_sequencer.sv - directed self-checking bench for multicycle_sequencer
// A small PC register and program table stand in for the datapath.
module tb_multicycle_sequencer;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BAD   = 7'b1111111;

  logic       clk, rst, run, step, halt_req, bp_en;
  logic [7:0] bp_addr, pc_q;
  logic [6:0] OP;
  logic       PCWrite, IRWrite, RegWrite, MemWrite, ResultSrc, busy, bp_hit, err;
  logic [2:0] state;
  logic [7:0] retired;
  logic [6:0] prog [64];

  int n_checks = 0;
  int n_fail   = 0;

  multicycle_sequencer dut (
    .clk(clk), .rst(rst), .run(run), .step(step), .halt_req(halt_req),
    .OP(OP), .PC(pc_q), .bp_en(bp_en), .bp_addr(bp_addr),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .RegWrite(RegWrite), .MemWrite(MemWrite),
    .ResultSrc(ResultSrc), .state(state), .busy(busy), .bp_hit(bp_hit), .err(err),
    .retired(retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst)         pc_q <= 8'd0;
    else if (PCWrite) pc_q <= pc_q + 8'd4;
  end

  assign OP = prog[pc_q[7:2]];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic fill(input logic [6:0] op);
    for (int i = 0; i < 64; i++) prog[i] = op;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 20 && state != 3'd0; i++) tick();
    check(tag, state, 3'd0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  logic [2:0] mix_st [14] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd1, 3'd2, 3'd3, 3'd4,
                              3'd1, 3'd2, 3'd3, 3'd5, 3'd0};
  logic [2:0] r_st [5] = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd0};
  int cnt;

  initial begin
    rst = 1'b0; run = 1'b0; step = 1'b0; halt_req = 1'b0; bp_en = 1'b0; bp_addr = 8'd0;
    fill(OP_R);
    tick();
    tick();
    check("rst_state", state, 3'd0);
    check("rst_retired", retired, 8'd0);
    check("rst_flags", {err, bp_hit, busy}, 3'b000);
    check("rst_enables", {PCWrite, IRWrite, RegWrite, MemWrite, ResultSrc}, 5'b0);
    rst = 1'b1;

    // single step of an R-type
    tick();
    step = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      step = 1'b0;
      check($sformatf("step_state%0d", i), state, r_st[i]);
      if (i == 0) check("step_irwrite", IRWrite, 1'b1);
      if (i == 3) check("step_wb_en", {RegWrite, PCWrite}, 2'b11);
    end
    check("step_retired", retired, 8'd1);
    check("step_pc", pc_q, 8'd4);

    // LOAD, STORE, I back-to-back in run mode
    prog[1] = OP_LOAD; prog[2] = OP_STORE; prog[3] = OP_I;
    run = 1'b1;
    for (int i = 0; i < 14; i++) begin
      tick();
      check($sformatf("mix_state%0d", i), state, mix_st[i]);
      check($sformatf("mix_memwrite%0d", i), MemWrite, (i == 8));
      check($sformatf("mix_resultsrc%0d", i), ResultSrc, (i == 4));
      check($sformatf("mix_pcwrite%0d", i), PCWrite, (i == 4 || i == 8 || i == 12));
      if (i == 12) run = 1'b0;
    end
    check("mix_retired", retired, 8'd4);
    check("mix_pc", pc_q, 8'd16);

    // breakpoint at 8
    fill(OP_R);
    do_reset();
    bp_en = 1'b1; bp_addr = 8'h08; run = 1'b1;
    for (int i = 0; i < 9; i++) tick();
    check("bp_state", state, 3'd0);
    check("bp_hit", bp_hit, 1'b1);
    check("bp_retired", retired, 8'd2);
    check("bp_pc", pc_q, 8'd8);
    tick();
    tick();
    check("bp_hold", {state, bp_hit}, {3'd0, 1'b1});
    step = 1'b1;
    tick();
    step = 1'b0;
    check("bp_step_fetch", state, 3'd1);
    check("bp_cleared", bp_hit, 1'b0);
    tick(); tick(); tick();
    check("bp_step_wb", state, 3'd5);
    tick();
    check("bp_step_idle", state, 3'd0);
    check("bp_step_retired", retired, 8'd3);
    check("bp_step_pc", pc_q, 8'd12);
    tick();
    check("bp_resume", state, 3'd1);
    check("bp_resume_pc", pc_q, 8'd12);
    run = 1'b0; bp_en = 1'b0;
    wait_idle("bp_stop_idle");
    check("bp_final_retired", retired, 8'd4);

    // halt during EXEC
    run = 1'b1;
    tick(); tick(); tick();
    check("halt_exec", state, 3'd3);
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    check("halt_wb", {state, PCWrite}, {3'd5, 1'b1});
    tick();
    check("halt_idle", state, 3'd0);
    check("halt_retired", retired, 8'd5);
    run = 1'b0;
    tick();
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    run = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    check("idle_halt_wb", state, 3'd5);
    tick();
    check("idle_halt_ignored", state, 3'd1);
    run = 1'b0;
    wait_idle("idle_halt_stop");
    check("idle_halt_retired", retired, 8'd7);

    // reset during MEM of a LOAD
    fill(OP_LOAD);
    run = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    check("rst_mid_mem", state, 3'd4);
    rst = 1'b0; run = 1'b0;
    tick();
    rst = 1'b1;
    check("rst_mid_state", state, 3'd0);
    check("rst_mid_regwrite", RegWrite, 1'b0);
    check("rst_mid_retired", retired, 8'd0);

    // retire 256 instructions for wrap
    fill(OP_R);
    run = 1'b1;
    cnt = 0;
    for (int i = 0; i < 2000 && cnt < 256; i++) begin
      tick();
      if (PCWrite) begin
        cnt++;
        if (cnt == 256) begin
          check("wrap_pre", retired, 8'd255);
          run = 1'b0;
        end
      end
    end
    check("wrap_count", cnt, 256);
    tick();
    check("wrap_state", state, 3'd0);
    check("wrap_retired", retired, 8'd0);

    // illegal opcode
    prog[pc_q[7:2]] = OP_BAD;
    run = 1'b1;
    tick();
    tick();
    check("ill_decode", state, 3'd2);
    tick();
    check("ill_state", state, 3'd7);
    check("ill_err", err, 1'b1);
    check("ill_pcwrite", PCWrite, 1'b0);
    step = 1'b1;
    tick();
    step = 1'b0;
    tick(); tick();
    check("ill_sticky", {state, err}, {3'd7, 1'b1});
    check("ill_retired", retired, 8'd0);
    check("ill_enables", {PCWrite, IRWrite, RegWrite, MemWrite, ResultSrc, busy}, 6'b0);
    run = 1'b0;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("ill_reset", {state, err}, {3'd0, 1'b0});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
